// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, bus widths and the address range check.
package dmem_pkg;

  localparam int DM_ADDR_W = 32;
  localparam int DM_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // An address is backed by RAM when every bit at or above aw is zero.
  function automatic logic in_range(input logic [DM_ADDR_W-1:0] addr, input int unsigned aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// DataMemory bus between the core's EX/MEM stage (master) and the data memory (slave).
interface DataMemory;
  import dmem_pkg::*;

  logic                 en;
  logic                 we;
  logic [DM_ADDR_W-1:0] addr;
  logic [DM_DATA_W-1:0] wd;
  logic [DM_DATA_W-1:0] rd;
  logic                 stall;

  modport master (output en, output we, output addr, output wd, input rd, input stall);
  modport slave  (input en, input we, input addr, input wd, output rd, output stall);

endinterface

// File: rtl/bram_sp.sv
// Single-port 32-bit RAM, synchronous read with read enable, no content reset.
// Read data appears one cycle after re; written for block-RAM inference.
module bram_sp #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wd,
  output logic [31:0]           rd
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wd;
    if (re) rd <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// DataMemory slave over a synchronous-read RAM: load miss stalls one cycle, hit register gives
// zero-stall repeat loads, stores never stall; out-of-range accesses set a sticky error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int HIT_BUF    = 1
) (
  input  logic           clock,
  input  logic           reset,
  DataMemory.slave       m_data,
  output logic           err,
  output logic [31:0]    err_addr
);

  state_t state, state_nxt;

  logic                  ok;
  logic                  hit;
  logic                  ram_we;
  logic                  ram_re;
  logic                  hit_load;
  logic                  oor;
  logic [31:0]           ram_q;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  hit_vld;
  logic [ADDR_WIDTH-1:0] hit_addr;
  logic [31:0]           hit_data;

  assign ok  = in_range(m_data.addr, ADDR_WIDTH);
  assign hit = (HIT_BUF != 0) && hit_vld && (hit_addr == m_data.addr[ADDR_WIDTH-1:0]);

  bram_sp #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (m_data.addr[ADDR_WIDTH-1:0]),
    .wd    (m_data.wd),
    .rd    (ram_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (m_data.en && ok && !m_data.we && !hit) state_nxt = WAIT;
      WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is gated by reset so the bus sees stall=0/rd=0 while it is held low.
  always_comb begin
    m_data.stall = 1'b0;
    m_data.rd    = '0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    hit_load     = 1'b0;
    oor          = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (m_data.en) begin
            if (!ok) begin
              oor = 1'b1;
            end else if (m_data.we) begin
              ram_we = 1'b1;
            end else if (hit) begin
              m_data.rd = hit_data;
            end else begin
              m_data.stall = 1'b1;
              ram_re       = 1'b1;
            end
          end
        end
        WAIT: begin
          m_data.rd = ram_q;
          hit_load  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_addr <= '0;
      hit_vld  <= 1'b0;
      hit_addr <= '0;
      hit_data <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (ram_re) lat_addr <= m_data.addr[ADDR_WIDTH-1:0];
      if (hit_load) begin
        hit_vld  <= 1'b1;
        hit_addr <= lat_addr;
        hit_data <= ram_q;
      end else if (ram_we && hit_vld && hit_addr == m_data.addr[ADDR_WIDTH-1:0]) begin
        hit_data <= m_data.wd;
      end
      if (oor && !err) begin
        err      <= 1'b1;
        err_addr <= m_data.addr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench: two responders (hit register on/off) driven by directed and random transactions
// and compared with a memory/hit/error model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int AW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  DataMemory bus_a ();
  DataMemory bus_b ();

  logic        err_a, err_b;
  logic [31:0] erra_a, erra_b;

  dmem_responder #(.ADDR_WIDTH(AW), .HIT_BUF(1)) dut_a (
    .clock(clock), .reset(reset), .m_data(bus_a), .err(err_a), .err_addr(erra_a));
  dmem_responder #(.ADDR_WIDTH(AW), .HIT_BUF(0)) dut_b (
    .clock(clock), .reset(reset), .m_data(bus_b), .err(err_b), .err_addr(erra_b));

  int checks = 0;
  int passed = 0;

  // Reference model: plain memory image plus "which address did the last miss fetch" and error capture.
  logic [31:0] mem [longint];
  bit          hv [2];
  logic [31:0] ha [2];
  bit          ev [2];
  logic [31:0] ea [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic longint key(input int sel, input logic [31:0] a);
    return (longint'(sel) << 32) | longint'(a);
  endfunction

  function automatic logic get_stall(input int sel);
    return (sel == 0) ? bus_a.stall : bus_b.stall;
  endfunction

  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 0) ? bus_a.rd : bus_b.rd;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? err_a : err_b;
  endfunction

  function automatic logic [31:0] get_erra(input int sel);
    return (sel == 0) ? erra_a : erra_b;
  endfunction

  task automatic drive(input int sel, input logic en, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    bus_a.en = 1'b0; bus_b.en = 1'b0;
    if (sel == 0) begin
      bus_a.en = en; bus_a.we = we; bus_a.addr = a; bus_a.wd = d;
    end else begin
      bus_b.en = en; bus_b.we = we; bus_b.addr = a; bus_b.wd = d;
    end
  endtask

  // One request held until stall drops; starts and ends 1 time unit after a rising edge.
  task automatic xact(input int sel, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input string tag);
    int          stalls;
    int          exp_st;
    bit          done;
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    drive(sel, 1'b1, we, a, d);
    stalls = 0;
    done   = 1'b0;
    rdata  = '0;
    for (int i = 0; i < 4 && !done; i++) begin
      @(negedge clock);
      if (get_stall(sel) == 1'b0) begin
        rdata = get_rd(sel);
        done  = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clock);
      #1;
    end
    chk({tag, " completes"}, 32'(done), 32'd1);
    exp_rd = '0;
    if ((a >> AW) != 0) begin
      exp_st = 0;
      if (!ev[sel]) begin ev[sel] = 1'b1; ea[sel] = a; end
    end else if (we) begin
      exp_st = 0;
      mem[key(sel, a)] = d;
    end else begin
      exp_rd = mem[key(sel, a)];
      if (sel == 0 && hv[sel] && ha[sel] == a) begin
        exp_st = 0;
      end else begin
        exp_st = 1;
        hv[sel] = 1'b1;
        ha[sel] = a;
      end
    end
    chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_st));
    if (!we || (a >> AW) != 0) chk({tag, " rd"}, rdata, exp_rd);
    chk({tag, " err"}, 32'(get_err(sel)), 32'(ev[sel]));
    chk({tag, " err_addr"}, get_erra(sel), ea[sel]);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    bit          we;

    for (int s = 0; s < 2; s++) begin hv[s] = 0; ha[s] = '0; ev[s] = 0; ea[s] = '0; end
    drive(0, 1'b1, 1'b0, 32'd5, 32'd0);
    bus_b.en = 1'b1; bus_b.we = 1'b0; bus_b.addr = 32'd5; bus_b.wd = '0;
    #12;
    chk("reset stall", 32'(bus_a.stall), 32'd0);
    chk("reset rd", bus_a.rd, 32'd0);
    chk("reset err", 32'(err_a), 32'd0);
    chk("reset err_addr", erra_a, 32'd0);
    chk("reset stall b", 32'(bus_b.stall), 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) xact(s, 1'b1, 32'(i), $urandom, "prefill");

    xact(0, 1'b1, 32'd5, 32'h12345678, "store5");
    xact(0, 1'b0, 32'd5, 32'd0, "load5 cold");
    xact(0, 1'b0, 32'd5, 32'd0, "load5 hit");
    xact(1, 1'b1, 32'd5, 32'h12345678, "b store5");
    xact(1, 1'b0, 32'd5, 32'd0, "b load5");
    xact(1, 1'b0, 32'd5, 32'd0, "b load5 again");
    xact(0, 1'b1, 32'd5, 32'hDEADBEEF, "store5 wt");
    xact(0, 1'b0, 32'd5, 32'd0, "load5 after wt");

    xact(0, 1'b1, 32'h0001_0000, 32'hA5A5A5A5, "oor store");
    xact(0, 1'b0, 32'h0002_0000, 32'd0, "oor load");
    xact(0, 1'b0, 32'd0, 32'd0, "ram0 intact");

    xact(0, 1'b0, 32'd6, 32'd0, "load6");
    drive(0, 1'b1, 1'b0, 32'd7, 32'd0);
    @(negedge clock);
    chk("rst load7 stall", 32'(bus_a.stall), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("rst in wait stall", 32'(bus_a.stall), 32'd0);
    chk("rst in wait rd", bus_a.rd, 32'd0);
    chk("rst in wait err", 32'(err_a), 32'd0);
    chk("rst in wait err_addr", erra_a, 32'd0);
    for (int s = 0; s < 2; s++) begin hv[s] = 0; ev[s] = 0; ea[s] = '0; end
    @(posedge clock); #1;
    reset = 1'b1;
    xact(0, 1'b0, 32'd7, 32'd0, "load7 after rst");

    xact(0, 1'b0, 32'd1, 32'd0, "miss1");
    xact(0, 1'b0, 32'd2, 32'd0, "miss2");
    xact(0, 1'b0, 32'd3, 32'd0, "miss3");
    xact(0, 1'b0, 32'd3, 32'd0, "hit3");
    xact(0, 1'b0, 32'd2, 32'd0, "miss2 again");

    for (int n = 0; n < 300; n++) begin
      sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
      we  = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0001_0000;
      else                           a = 32'($urandom_range(0, 15));
      xact(sel, we, a, $urandom, "random");
    end

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
